// File: rtl/susan_pkg.sv
// Shared constants for the SUSAN corner-response datapath: USAN sum width,
// mask border, corner counter width and default image geometry.
package susan_pkg;
    localparam int SUM_WIDTH        = 14;
    localparam int MASK_BORDER      = 3;
    localparam int CORNER_CNT_WIDTH = 20;
    localparam int DEF_IMG_WIDTH    = 640;
    localparam int DEF_IMG_HEIGHT   = 480;
endpackage

// File: rtl/pix_pos_cnt.sv
// Raster position tracker: x/y of the next pixel to arrive plus frame flags and
// a border marker for pixels whose 7x7 neighbourhood is incomplete.
module pix_pos_cnt
    import susan_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int BORDER     = MASK_BORDER
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance,
    output logic [$clog2(IMG_WIDTH)-1:0]  x,
    output logic [$clog2(IMG_HEIGHT)-1:0] y,
    output logic                          sof,
    output logic                          eol,
    output logic                          eof,
    output logic                          border
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_LO   = XW'(BORDER);
    localparam logic [XW-1:0] X_HI   = XW'(IMG_WIDTH - 1 - BORDER);
    localparam logic [YW-1:0] Y_LO   = YW'(BORDER);
    localparam logic [YW-1:0] Y_HI   = YW'(IMG_HEIGHT - 1 - BORDER);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (advance) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign sof    = (r_x == '0) && (r_y == '0);
    assign eol    = (r_x == X_LAST);
    assign eof    = (r_x == X_LAST) && (r_y == Y_LAST);
    assign border = (r_x < X_LO) || (r_x > X_HI) || (r_y < Y_LO) || (r_y > Y_HI);
endmodule

// File: rtl/susan_response.sv
// SUSAN corner response R = g - n (zero when n >= g or on the mask border),
// tagged with raster position, plus a per-frame count of nonzero responses.
module susan_response #(
    parameter int IMG_WIDTH  = susan_pkg::DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = susan_pkg::DEF_IMG_HEIGHT,
    parameter int SUM_WIDTH  = susan_pkg::SUM_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    din_valid,
    input  logic [SUM_WIDTH-1:0]                    din_sum,
    input  logic [SUM_WIDTH-1:0]                    g_thresh,
    output logic                                    dout_valid,
    output logic [SUM_WIDTH-1:0]                    dout_resp,
    output logic [$clog2(IMG_WIDTH)-1:0]            dout_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]           dout_y,
    output logic                                    dout_sof,
    output logic                                    dout_eol,
    output logic                                    dout_eof,
    output logic [susan_pkg::CORNER_CNT_WIDTH-1:0]  frame_corners,
    output logic                                    frame_done
);
    import susan_pkg::*;

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int CW = CORNER_CNT_WIDTH;
    localparam logic [CW-1:0] CNT_MAX = '1;

    function automatic logic [SUM_WIDTH-1:0] usan_resp(input logic [SUM_WIDTH-1:0] n,
                                                       input logic [SUM_WIDTH-1:0] g,
                                                       input logic             brd);
        return (!brd && (n < g)) ? (g - n) : '0;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
        return (inc && (c != CNT_MAX)) ? (c + CW'(1)) : c;
    endfunction

    logic [XW-1:0]        w_x;
    logic [YW-1:0]        w_y;
    logic                 w_sof, w_eol, w_eof, w_border;
    logic [SUM_WIDTH-1:0] w_resp_p0;
    logic                 w_hit_p0;

    logic                 r_vld_p0, r_sof_p0, r_eol_p0, r_eof_p0, r_border_p0;
    logic [SUM_WIDTH-1:0] r_sum_p0, r_g_p0;
    logic [XW-1:0]        r_x_p0;
    logic [YW-1:0]        r_y_p0;

    logic                 r_vld_p1, r_sof_p1, r_eol_p1, r_eof_p1;
    logic [SUM_WIDTH-1:0] r_resp_p1;
    logic [XW-1:0]        r_x_p1;
    logic [YW-1:0]        r_y_p1;
    logic [CW-1:0]        r_cnt, r_frame_corners;
    logic                 r_frame_done;

    pix_pos_cnt #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .BORDER     (MASK_BORDER)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .advance(din_valid),
        .x      (w_x),
        .y      (w_y),
        .sof    (w_sof),
        .eol    (w_eol),
        .eof    (w_eof),
        .border (w_border)
    );

    // Stage p0: capture the beat, its threshold and its raster position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0    <= 1'b0;
            r_sum_p0    <= '0;
            r_g_p0      <= '0;
            r_x_p0      <= '0;
            r_y_p0      <= '0;
            r_sof_p0    <= 1'b0;
            r_eol_p0    <= 1'b0;
            r_eof_p0    <= 1'b0;
            r_border_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= din_valid;
            if (din_valid) begin
                r_sum_p0    <= din_sum;
                r_g_p0      <= g_thresh;
                r_x_p0      <= w_x;
                r_y_p0      <= w_y;
                r_sof_p0    <= w_sof;
                r_eol_p0    <= w_eol;
                r_eof_p0    <= w_eof;
                r_border_p0 <= w_border;
            end
        end
    end

    assign w_resp_p0 = usan_resp(r_sum_p0, r_g_p0, r_border_p0);
    assign w_hit_p0  = (w_resp_p0 != '0);

    // Stage p1: output registers and the frame corner tally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1        <= 1'b0;
            r_resp_p1       <= '0;
            r_x_p1          <= '0;
            r_y_p1          <= '0;
            r_sof_p1        <= 1'b0;
            r_eol_p1        <= 1'b0;
            r_eof_p1        <= 1'b0;
            r_cnt           <= '0;
            r_frame_corners <= '0;
            r_frame_done    <= 1'b0;
        end else begin
            r_vld_p1     <= r_vld_p0;
            r_sof_p1     <= r_vld_p0 && r_sof_p0;
            r_eol_p1     <= r_vld_p0 && r_eol_p0;
            r_eof_p1     <= r_vld_p0 && r_eof_p0;
            r_frame_done <= r_vld_p0 && r_eof_p0;
            if (r_vld_p0) begin
                r_resp_p1 <= w_resp_p0;
                r_x_p1    <= r_x_p0;
                r_y_p1    <= r_y_p0;
                if (r_eof_p0) begin
                    r_frame_corners <= sat_inc(r_cnt, w_hit_p0);
                    r_cnt           <= '0;
                end else begin
                    r_cnt <= sat_inc(r_cnt, w_hit_p0);
                end
            end
        end
    end

    assign dout_valid    = r_vld_p1;
    assign dout_resp     = r_resp_p1;
    assign dout_x        = r_x_p1;
    assign dout_y        = r_y_p1;
    assign dout_sof      = r_sof_p1;
    assign dout_eol      = r_eol_p1;
    assign dout_eof      = r_eof_p1;
    assign frame_corners = r_frame_corners;
    assign frame_done    = r_frame_done;
endmodule

// File: tb/tb_susan_response.sv
// Directed bench for susan_response on an 8x8 image with g = 2775, checked
// every cycle against a raster-index model of the response stream.
module tb_susan_response;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int SW = 14;
    localparam int G  = 2775;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [SW-1:0] din_sum = '0;
    logic [SW-1:0] g_thresh = SW'(G);
    logic          dout_valid, dout_sof, dout_eol, dout_eof, frame_done;
    logic [SW-1:0] dout_resp;
    logic [2:0]    dout_x, dout_y;
    logic [19:0]   frame_corners;

    susan_response #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_sum(din_sum),
        .g_thresh(g_thresh), .dout_valid(dout_valid), .dout_resp(dout_resp),
        .dout_x(dout_x), .dout_y(dout_y), .dout_sof(dout_sof), .dout_eol(dout_eol),
        .dout_eof(dout_eof), .frame_corners(frame_corners), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x;
        int y;
        int r;
        bit sof;
        bit eol;
        bit eof;
    } beat_t;

    beat_t q[$];
    int    fc_hist[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    bidx = 0;
    int    mcnt = 0;
    int    mfc = 0;
    int    fd_cyc = 0;
    int    in_cyc = 0;
    bit    want_first = 1'b0;
    int    obs_r [64];
    int    ref_r [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int pk(input int x, input int y, input int r, input bit s, input bit l, input bit f);
        return (x << 20) | (y << 17) | (r << 3) | (int'(s) << 2) | (int'(l) << 1) | int'(f);
    endfunction

    function automatic int pix_val(input int mode, input int idx);
        int  x = idx % W;
        int  y = idx / W;
        bit  inner = (x >= 3) && (x <= W - 4) && (y >= 3) && (y <= H - 4);
        case (mode)
            0: return 1000;
            1: return (idx == 27) ? 2775 : (idx == 28) ? 2776 : (idx == 35) ? 0 : 4000;
            2: return inner ? 0 : 1000;
            default: return inner ? 3000 : 500;
        endcase
    endfunction

    task automatic beat(input int n);
        beat_t b;
        int x = bidx % W;
        int y = bidx / W;
        bit inner = (x >= 3) && (x <= W - 4) && (y >= 3) && (y <= H - 4);
        @(negedge clk);
        din_valid = 1'b1;
        din_sum   = SW'(n);
        b.due = cyc + 2;
        b.x   = x;
        b.y   = y;
        b.r   = (inner && n < G) ? G - n : 0;
        b.sof = (bidx == 0);
        b.eol = (x == W - 1);
        b.eof = (bidx == W * H - 1);
        q.push_back(b);
        in_cyc = cyc;
        bidx = (bidx + 1) % (W * H);
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic run(input int mode, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            beat(pix_val(mode, bidx));
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 64; i++) obs_r[i] = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        din_valid = 1'b0;
        q.delete();
        bidx = 0;
        mcnt = 0;
        mfc = 0;
        want_first = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model queue
    always @(negedge clk) begin
        beat_t e;
        bit    ev;
        if (!rst) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            check(dout_valid == ev, "dout_valid", int'(dout_valid), int'(ev));
            if (ev) begin
                e = q.pop_front();
                check(pk(int'(dout_x), int'(dout_y), int'(dout_resp), dout_sof, dout_eol, dout_eof)
                      == pk(e.x, e.y, e.r, e.sof, e.eol, e.eof), "beat_fields",
                      pk(int'(dout_x), int'(dout_y), int'(dout_resp), dout_sof, dout_eol, dout_eof),
                      pk(e.x, e.y, e.r, e.sof, e.eol, e.eof));
                if (e.r != 0) mcnt++;
                if (e.eof) begin
                    mfc  = mcnt;
                    mcnt = 0;
                end
                obs_r[e.y * W + e.x] = int'(dout_resp);
                if (want_first) begin
                    check(dout_x == 0 && dout_y == 0 && dout_sof, "first_after_reset",
                          pk(int'(dout_x), int'(dout_y), 0, dout_sof, 1'b0, 1'b0), pk(0, 0, 0, 1'b1, 1'b0, 1'b0));
                    want_first = 1'b0;
                end
            end
            check(frame_done == (ev && e.eof), "frame_done", int'(frame_done), int'(ev && e.eof));
            check(int'(frame_corners) == mfc, "frame_corners", int'(frame_corners), mfc);
            if (frame_done) begin
                fc_hist.push_back(int'(frame_corners));
                fd_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        clear_obs();
        repeat (3) @(negedge clk);
        check(dout_valid == 0 && frame_done == 0, "reset_ctrl", int'({dout_valid, frame_done}), 0);
        check(frame_corners == 0, "reset_corners", int'(frame_corners), 0);
        check(dout_x == 0 && dout_y == 0 && dout_resp == 0, "reset_data",
              int'({dout_x, dout_y, dout_resp}), 0);
        #2 rst = 1'b0;

        run(0, 64, 1'b0);
        idle(5);
        check(fc_hist.size() == 1 && fc_hist[fc_hist.size() - 1] == 4, "gapless_corners",
              fc_hist[fc_hist.size() - 1], 4);
        check(obs_r[27] == 1775 && obs_r[36] == 1775, "interior_r", obs_r[27], 1775);
        check(obs_r[0] == 0 && obs_r[26] == 0 && obs_r[37] == 0, "border_r", obs_r[26], 0);
        check(fd_cyc - in_cyc == 2, "eof_latency", fd_cyc - in_cyc, 2);
        for (int i = 0; i < 64; i++) ref_r[i] = obs_r[i];

        clear_obs();
        run(1, 64, 1'b0);
        idle(5);
        check(obs_r[27] == 0, "r_eq_g", obs_r[27], 0);
        check(obs_r[28] == 0, "r_gt_g", obs_r[28], 0);
        check(obs_r[35] == 2775, "r_zero_sum", obs_r[35], 2775);
        check(fc_hist[fc_hist.size() - 1] == 1, "special_corners", fc_hist[fc_hist.size() - 1], 1);

        clear_obs();
        run(0, 64, 1'b1);
        idle(5);
        check(fc_hist[fc_hist.size() - 1] == 4, "gap_corners", fc_hist[fc_hist.size() - 1], 4);
        snap = 0;
        for (int i = 0; i < 64; i++) if (obs_r[i] != ref_r[i]) snap++;
        check(snap == 0, "gap_vs_gapless", snap, 0);

        run(0, 20, 1'b0);
        do_reset();
        @(negedge clk);
        check(frame_corners == 0, "corners_after_reset", int'(frame_corners), 0);
        snap = fc_hist.size();
        run(0, 63, 1'b0);
        idle(4);
        check(fc_hist.size() == snap, "no_early_done", fc_hist.size(), snap);
        run(0, 1, 1'b0);
        idle(4);
        check(fc_hist.size() == snap + 1 && fc_hist[fc_hist.size() - 1] == 4, "done_after_64",
              fc_hist.size(), snap + 1);

        snap = fc_hist.size();
        run(2, 64, 1'b0);
        run(3, 64, 1'b0);
        idle(5);
        check(fc_hist.size() == snap + 2, "b2b_done_count", fc_hist.size(), snap + 2);
        check(fc_hist[fc_hist.size() - 2] == 4, "b2b_frame1", fc_hist[fc_hist.size() - 2], 4);
        check(fc_hist[fc_hist.size() - 1] == 0, "b2b_frame2", fc_hist[fc_hist.size() - 1], 0);
        check(q.size() == 0, "queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/susan_response.md
SUSAN_RESPONSE -- requirements
Module: susan_response

Interface
REQ-001 The module SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line (minimum 8).
REQ-002 The module SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame (minimum 8).
REQ-003 The module SHALL have parameter SUM_WIDTH, default 14, meaning the width of the USAN area input from the 37-input adder tree.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port din_valid, input, 1 bit: din_sum is valid this cycle (the adder tree's dout_valid).
REQ-007 The module SHALL have port din_sum, input, SUM_WIDTH bits: the unsigned USAN area n for one pixel, in raster order.
REQ-008 The module SHALL have port g_thresh, input, SUM_WIDTH bits: the geometric threshold g, quasi-static.
REQ-009 The module SHALL have port dout_valid, output, 1 bit: output beat valid.
REQ-010 The module SHALL have port dout_resp, output, SUM_WIDTH bits: the corner response R.
REQ-011 The module SHALL have ports dout_x and dout_y, outputs, $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits: the pixel coordinates.
REQ-012 The module SHALL have ports dout_sof, dout_eol and dout_eof, outputs, 1 bit each: first pixel of frame, last pixel of line, and last pixel of frame.
REQ-013 The module SHALL have port frame_corners, output, 20 bits: the count of nonzero responses in the last completed frame.
REQ-014 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse when frame_corners updates.

Function
REQ-015 Latency SHALL be exactly 2 clk cycles from a din_valid beat to its dout_valid beat; there is no backpressure and one beat is accepted per cycle.
REQ-016 Gaps in din_valid SHALL be allowed; the position counters and outputs SHALL advance only on valid beats, and dout_valid is 0 in gap cycles.
REQ-017 The x counter SHALL increment per valid beat and wrap from IMG_WIDTH-1 to 0, incrementing y; y SHALL wrap from IMG_HEIGHT-1 to 0 (the next frame).
REQ-018 R SHALL be g_thresh - din_sum when din_sum < g_thresh, else 0 (this includes din_sum == g and g == 0); the subtraction is unsigned with no overflow possible.
REQ-019 g_thresh SHALL be sampled in the same cycle as its din_sum beat.
REQ-020 Border pixels (x<3, x>IMG_WIDTH-4, y<3, y>IMG_HEIGHT-4) SHALL force R=0, because the 7x7 mask is incomplete there.
REQ-021 dout_sof SHALL assert at (0,0), dout_eol at x=IMG_WIDTH-1, and dout_eof at (IMG_WIDTH-1, IMG_HEIGHT-1); all three SHALL be qualified by dout_valid.
REQ-022 The internal corner counter SHALL increment on each output beat with R != 0 and saturate at 2^20-1.
REQ-023 On the dout_eof beat, frame_corners SHALL load the count including that beat, frame_done SHALL pulse in the same cycle, and the counter SHALL clear to 0.
REQ-024 frame_corners SHALL hold its value until the next frame_done.

Reset
REQ-025 rst SHALL asynchronously clear the x/y counters, the corner counter, the pipeline registers, and all outputs to 0.
REQ-026 In-flight beats SHALL be discarded on reset; after reset deassertion, the first valid beat SHALL be pixel (0,0), even if reset occurred mid-frame.

Structure
REQ-027 Package susan_pkg SHALL hold SUM_WIDTH=14, MASK_BORDER=3, CORNER_CNT_WIDTH=20 and the default image dimensions.
REQ-028 The raster position logic SHALL be a sub-module pix_pos_cnt (inputs clk, rst, advance; outputs x, y, sof, eol, eof, border), which is reusable by the upstream window generator.

Verification (IMG_WIDTH=8, IMG_HEIGHT=8, g_thresh=2775)
REQ-029 The bench SHALL drive 64 contiguous beats with din_sum=1000 and check: interior 2x2 pixels R=1775, all others R=0, frame_corners=4, and frame_done high with dout_eof 2 cycles after the 64th input.
REQ-030 The bench SHALL drive an interior pixel with din_sum=2775, then 2776, then 0, and check R=0, 0, 2775 respectively.
REQ-031 The bench SHALL insert random 1-3 cycle din_valid gaps over one frame and check that coordinates, flags and frame_corners match the gapless run exactly.
REQ-032 The bench SHALL assert rst at beat 20 of a frame, then resume, and check that the first output is (0,0) with dout_sof=1, frame_corners=0, and that the next frame_done occurs only after 64 further beats.
REQ-033 The bench SHALL run two back-to-back frames (interior din_sum=0 in frame 1, 3000 in frame 2) and check frame_corners=4, then 0, with no lost beat across the frame boundary.
